compound_arbiter: RTL and testbench
===================================

COMPOUND_ARBITER -- requirements
Module: compound_arbiter

Interface
REQ-001 The block SHALL use reset rst, asynchronous, active-high, and clock clk.
REQ-002 The block SHALL have these ports:
- clk  in  1  clock
- rst  in  1  async active-high reset
- req0_in  in  CompoundType (testbasic12_types: mode, x integer, y logic)  requester 0 payload
- req0_in_sync  in  1  requester 0 has a transaction pending
- req0_in_notify  out  1  arbiter ready to read requester 0
- req1_in, req1_in_sync, req1_in_notify  same as requester 0, for requester 1
- grant_out  out  CompoundType  forwarded payload
- grant_out_notify  out  1  grant_out valid, blocking write pending
- grant_out_sync  in  1  downstream accepts grant_out
- grant_id  out  1  source of current grant_out (0/1)
- count_out  out  32 (integer)  number of completed forwards
REQ-003 The block SHALL treat a transfer on any port as occurring on a rising clk edge where that port's notify and sync are both high.

Function
REQ-004 The block SHALL implement a 3-state FSM: POLL, READ, WRITE.
REQ-005 In POLL, the block SHALL hold req0_in_notify, req1_in_notify and grant_out_notify low.
REQ-006 In POLL, on an edge with exactly one reqN_in_sync high, the block SHALL select N, set reqN_in_notify high and go to READ.
REQ-007 In POLL, on an edge with both syncs high, the block SHALL select the requester indicated by the priority pointer ptr.
REQ-008 In POLL, with no sync high, the block SHALL stay in POLL.
REQ-009 In READ, the block SHALL keep only the selected requester's notify high and stay until that requester's sync is high.
REQ-010 On the READ transfer edge, the block SHALL:
- capture reqN_in into grant_out
- set grant_id to N
- drop reqN_in_notify
- set grant_out_notify high
- go to WRITE
REQ-011 In WRITE, the block SHALL hold grant_out and grant_id stable with grant_out_notify high until grant_out_sync is high.
REQ-012 On the WRITE transfer edge, the block SHALL:
- drop grant_out_notify
- increment count_out by 1
- set ptr to the requester not just served
- go to POLL
REQ-013 The non-selected requester's sync SHALL be ignored outside POLL; its notify SHALL remain low.
REQ-014 Zero-wait-state latency (sync in POLL at edge N, sync held, grant_out_sync already high) SHALL be: notify at cycle N+1, grant_out_notify at N+2, back in POLL at N+3; throughput one grant per 3 cycles.
REQ-015 count_out SHALL wrap two's-complement from 2147483647 to -2147483648.
REQ-016 Payload SHALL be forwarded unmodified, including all mode, x and y values.
REQ-017 The block SHALL never assert both req notifies in the same cycle.

Reset
REQ-018 While rst is high, the block SHALL force:
- FSM state POLL
- ptr 0
- req0_in_notify, req1_in_notify and grant_out_notify 0
- grant_out.mode read, grant_out.x 0, grant_out.y 1'b0
- grant_id 0
- count_out 0
REQ-019 Reset asserted in READ or WRITE SHALL abort the pending transaction without incrementing count_out; the block SHALL restart in POLL on the first edge after rst falls.

Verification
REQ-020 Single requester: req0 sync with {write,5,1}, grant_out_sync tied 1 -> grant_out={write,5,1}, grant_id=0, grant_out_notify high one cycle, count_out=1, POLL after 3 cycles.
REQ-021 Contention: both syncs held high continuously, downstream always ready -> grant_id sequence 0,1,0,1; count_out=4 after 12 cycles; never both notifies high.
REQ-022 Backpressure: grant_out_sync low for 10 cycles during WRITE -> grant_out, grant_id and notify stable for all 10 cycles; count_out increments only on the edge where sync rises.
REQ-023 Requester stall: req1 sync drops in READ for 4 cycles -> req1_in_notify held high, no capture, FSM stays in READ; capture on the edge where sync returns.
REQ-024 Reset mid-WRITE: assert rst with grant_out_notify=1 and count_out=7 -> all outputs at reset values, count_out=0, ptr=0; next contention grants req0 first.
REQ-025 Wrap: preload count_out to 2147483647 via repeated grants (or force), one more grant -> count_out=-2147483648.

Source files
------------

// File: rtl/compound_arbiter.sv
// Two-requester arbiter forwarding a compound payload {mode, x, y} to one blocking writer.
// Payload packing: [33] mode (0 = read, 1 = write), [32:1] x, [0] y.
module compound_arbiter (
  input  logic        clk,
  input  logic        rst,
  input  logic [33:0] req0_in,
  input  logic        req0_in_sync,
  output logic        req0_in_notify,
  input  logic [33:0] req1_in,
  input  logic        req1_in_sync,
  output logic        req1_in_notify,
  output logic [33:0] grant_out,
  output logic        grant_out_notify,
  input  logic        grant_out_sync,
  output logic        grant_id,
  output logic [31:0] count_out
);

  typedef enum logic [1:0] {
    StPoll,
    StRead,
    StWrite
  } state_e;

  state_e      r_state;
  state_e      w_state_nxt;
  logic        r_sel;
  logic        w_sel_nxt;
  logic        r_ptr;
  logic [33:0] r_grant;
  logic        r_grant_id;
  logic [31:0] r_count;
  logic        w_sel_sync;
  logic        w_capture;
  logic        w_done;

  assign w_sel_sync = r_sel ? req1_in_sync : req0_in_sync;

  always_comb begin
    w_state_nxt = r_state;
    w_sel_nxt   = r_sel;
    w_capture   = 1'b0;
    w_done      = 1'b0;
    unique case (r_state)
      StPoll: begin
        if (req0_in_sync && req1_in_sync) begin
          w_sel_nxt   = r_ptr;
          w_state_nxt = StRead;
        end else if (req0_in_sync) begin
          w_sel_nxt   = 1'b0;
          w_state_nxt = StRead;
        end else if (req1_in_sync) begin
          w_sel_nxt   = 1'b1;
          w_state_nxt = StRead;
        end
      end
      StRead: begin
        if (w_sel_sync) begin
          w_capture   = 1'b1;
          w_state_nxt = StWrite;
        end
      end
      StWrite: begin
        if (grant_out_sync) begin
          w_done      = 1'b1;
          w_state_nxt = StPoll;
        end
      end
      default: w_state_nxt = StPoll;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= StPoll;
      r_sel      <= 1'b0;
      r_ptr      <= 1'b0;
      r_grant    <= '0;
      r_grant_id <= 1'b0;
      r_count    <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_sel   <= w_sel_nxt;
      if (w_capture) begin
        r_grant    <= r_sel ? req1_in : req0_in;
        r_grant_id <= r_sel;
      end
      if (w_done) begin
        r_count <= r_count + 32'd1;
        // Priority passes to whichever requester was not just served.
        r_ptr   <= ~r_grant_id;
      end
    end
  end

  assign req0_in_notify   = (r_state == StRead) && !r_sel;
  assign req1_in_notify   = (r_state == StRead) && r_sel;
  assign grant_out_notify = (r_state == StWrite);
  assign grant_out        = r_grant;
  assign grant_id         = r_grant_id;
  assign count_out        = r_count;

endmodule

// File: tb/tb_compound_arbiter.sv
// Bench for compound_arbiter: directed scenarios plus random traffic, all cycles checked
// against a transaction-level model of the arbiter.
module tb_compound_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [33:0] req0_in, req1_in;
  logic        req0_in_sync, req1_in_sync;
  logic        req0_in_notify, req1_in_notify;
  logic [33:0] grant_out;
  logic        grant_out_notify, grant_out_sync;
  logic        grant_id;
  logic [31:0] count_out;

  int checks = 0;
  int failures = 0;

  // Model: phase 0 idle, 1 waiting for the chosen requester, 2 waiting for downstream.
  int          m_phase;
  int          m_sel;
  int          m_ptr;
  int          m_id;
  logic [33:0] m_grant;
  logic [31:0] m_count;

  always #5 clk = ~clk;

  compound_arbiter dut (
    .clk              (clk),
    .rst              (rst),
    .req0_in          (req0_in),
    .req0_in_sync     (req0_in_sync),
    .req0_in_notify   (req0_in_notify),
    .req1_in          (req1_in),
    .req1_in_sync     (req1_in_sync),
    .req1_in_notify   (req1_in_notify),
    .grant_out        (grant_out),
    .grant_out_notify (grant_out_notify),
    .grant_out_sync   (grant_out_sync),
    .grant_id         (grant_id),
    .count_out        (count_out)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [33:0] rand_payload();
    logic [33:0] p;
    p = {1'($urandom_range(0, 1)), 32'($urandom), 1'($urandom_range(0, 1))};
    return p;
  endfunction

  function automatic void model_reset();
    m_phase = 0;
    m_sel   = 0;
    m_ptr   = 0;
    m_id    = 0;
    m_grant = '0;
    m_count = '0;
  endfunction

  function automatic void model_edge();
    if (m_phase == 0) begin
      if (req0_in_sync && req1_in_sync) begin
        m_sel = m_ptr;
        m_phase = 1;
      end else if (req0_in_sync || req1_in_sync) begin
        m_sel = req0_in_sync ? 0 : 1;
        m_phase = 1;
      end
    end else if (m_phase == 1) begin
      if ((m_sel == 0) ? req0_in_sync : req1_in_sync) begin
        m_grant = (m_sel == 0) ? req0_in : req1_in;
        m_id    = m_sel;
        m_phase = 2;
      end
    end else if (grant_out_sync) begin
      m_count = m_count + 1;
      m_ptr   = 1 - m_id;
      m_phase = 0;
    end
  endfunction

  task automatic check_outputs();
    check_eq("req0_notify", 64'(req0_in_notify), 64'(m_phase == 1 && m_sel == 0));
    check_eq("req1_notify", 64'(req1_in_notify), 64'(m_phase == 1 && m_sel == 1));
    check_eq("grant_notify", 64'(grant_out_notify), 64'(m_phase == 2));
    check_eq("grant_out", 64'(grant_out), 64'(m_grant));
    check_eq("grant_id", 64'(grant_id), 64'(m_id));
    check_eq("count_out", 64'(count_out), 64'(m_count));
    check_eq("notify_mutex", 64'(req0_in_notify & req1_in_notify), 64'd0);
  endtask

  task automatic cycle();
    @(posedge clk);
    if (!rst) model_edge();
    @(negedge clk);
    check_outputs();
  endtask

  // Asynchronous assertion is checked before any clock edge occurs.
  task automatic apply_reset();
    rst = 1'b1;
    #1;
    model_reset();
    check_outputs();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic idle_inputs();
    req0_in_sync   = 1'b0;
    req1_in_sync   = 1'b0;
    grant_out_sync = 1'b1;
  endtask

  initial begin
    int          ids[$];
    logic [33:0] snap_grant;
    logic        snap_id;
    logic [33:0] late;
    int          budget;

    req0_in = '0;
    req1_in = '0;
    idle_inputs();
    rst = 1'b0;
    @(negedge clk);
    apply_reset();

    // Single requester, downstream always ready.
    req0_in      = {1'b1, 32'd5, 1'b1};
    req0_in_sync = 1'b1;
    cycle();
    check_eq("single_notify_n1", 64'(req0_in_notify), 64'd1);
    cycle();
    req0_in_sync = 1'b0;
    check_eq("single_grant", 64'(grant_out), 64'h2_0000_000B);
    check_eq("single_id", 64'(grant_id), 64'd0);
    check_eq("single_gnotify", 64'(grant_out_notify), 64'd1);
    cycle();
    check_eq("single_count", 64'(count_out), 64'd1);
    check_eq("single_back_poll", 64'(grant_out_notify), 64'd0);

    // Contention: both requesters always pending.
    apply_reset();
    req0_in      = rand_payload();
    req1_in      = rand_payload();
    req0_in_sync = 1'b1;
    req1_in_sync = 1'b1;
    for (int i = 0; i < 12; i++) begin
      cycle();
      if (grant_out_notify) ids.push_back(int'(grant_id));
    end
    idle_inputs();
    check_eq("cont_grants", 64'(ids.size()), 64'd4);
    for (int i = 0; i < ids.size(); i++) check_eq("cont_id_seq", 64'(ids[i]), 64'(i % 2));
    check_eq("cont_count", 64'(count_out), 64'd4);

    // Backpressure: downstream stalls 10 cycles in the write phase.
    grant_out_sync = 1'b0;
    req1_in        = rand_payload();
    req1_in_sync   = 1'b1;
    cycle();
    cycle();
    req1_in_sync = 1'b0;
    snap_grant   = grant_out;
    snap_id      = grant_id;
    for (int i = 0; i < 10; i++) begin
      cycle();
      check_eq("bp_grant_stable", 64'(grant_out), 64'(snap_grant));
      check_eq("bp_id_stable", 64'(grant_id), 64'(snap_id));
      check_eq("bp_notify_held", 64'(grant_out_notify), 64'd1);
      check_eq("bp_count_held", 64'(count_out), 64'd4);
    end
    grant_out_sync = 1'b1;
    cycle();
    check_eq("bp_count_inc", 64'(count_out), 64'd5);

    // Requester stall; the other requester's sync must be ignored meanwhile.
    req1_in      = rand_payload();
    req1_in_sync = 1'b1;
    cycle();
    req1_in_sync = 1'b0;
    req0_in_sync = 1'b1;
    for (int i = 0; i < 4; i++) begin
      req1_in = rand_payload();
      cycle();
      check_eq("stall_notify1", 64'(req1_in_notify), 64'd1);
      check_eq("stall_no_write", 64'(grant_out_notify), 64'd0);
    end
    late         = rand_payload();
    req1_in      = late;
    req1_in_sync = 1'b1;
    cycle();
    req1_in_sync = 1'b0;
    req0_in_sync = 1'b0;
    check_eq("stall_capture", 64'(grant_out), 64'(late));
    cycle();

    // One more grant to reach 7, then reset in the middle of a write.
    req0_in      = rand_payload();
    req0_in_sync = 1'b1;
    cycle();
    cycle();
    req0_in_sync = 1'b0;
    cycle();
    check_eq("pre_rst_count", 64'(count_out), 64'd7);
    grant_out_sync = 1'b0;
    req0_in_sync   = 1'b1;
    cycle();
    cycle();
    req0_in_sync = 1'b0;
    check_eq("pre_rst_gnotify", 64'(grant_out_notify), 64'd1);
    apply_reset();
    check_eq("rst_count_zero", 64'(count_out), 64'd0);
    grant_out_sync = 1'b1;
    req0_in_sync   = 1'b1;
    req1_in_sync   = 1'b1;
    cycle();
    cycle();
    check_eq("rst_first_grant_req0", 64'(grant_id), 64'd0);
    idle_inputs();
    cycle();

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      req0_in        = rand_payload();
      req1_in        = rand_payload();
      req0_in_sync   = ($urandom_range(0, 2) != 0);
      req1_in_sync   = ($urandom_range(0, 2) != 0);
      grant_out_sync = ($urandom_range(0, 3) != 0);
      cycle();
    end
    idle_inputs();
    budget = 0;
    while (m_phase != 0 && budget < 10) begin
      cycle();
      budget++;
    end
    check_eq("drain_timeout", 64'(m_phase), 64'd0);

    // Counter wrap from the largest positive value.
    force dut.r_count = 32'h7FFF_FFFF;
    #1;
    release dut.r_count;
    m_count = 32'h7FFF_FFFF;
    check_eq("wrap_preload", 64'(count_out), 64'h7FFF_FFFF);
    req0_in      = rand_payload();
    req0_in_sync = 1'b1;
    cycle();
    cycle();
    req0_in_sync = 1'b0;
    cycle();
    check_eq("wrap_count", 64'(count_out), 64'h8000_0000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
